// File: rtl/loader_pkg.sv
// Shared types and constants for the configuration bitstream loader.
package loader_pkg;

  localparam int unsigned WORD_W = 8;

  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CRC  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  // One serial CRC-8 step: feedback is the outgoing MSB xor the new bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 accumulator; one bit folded in per enabled cycle.
module crc8_serial
  import loader_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;

  // Clear wins over a same-cycle update so a new load always starts from init.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_crc <= CRC_INIT;
    end else if (i_clr) begin
      r_crc <= CRC_INIT;
    end else if (i_en) begin
      r_crc <= crc8_step(r_crc, i_bit);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/cfg_bitstream_loader.sv
// Byte-stream to programming scan chain serialiser with trailing CRC-8 check.
module cfg_bitstream_loader #(
  parameter int unsigned CHAIN_LEN = 1024,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              prog_in,
  output logic              prog_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import loader_pkg::*;

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned VLD_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [WORD_W-1:0] r_buf;
  logic [VLD_W-1:0]  r_vld;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_prog_in;
  logic              r_prog_en;
  logic              r_done;
  logic              r_err;

  logic              w_start_load;
  logic              w_active;
  logic              w_shift;
  logic              w_last_bit;
  logic              w_accept;
  logic              w_s_ready;
  logic              w_busy;
  logic              w_crc_match;
  logic [7:0]        w_crc;

  // A bit leaves the buffer whenever one is held in LOAD and no abort is pending.
  assign w_start_load = (r_state == ST_IDLE) && start;
  assign w_active     = (r_state == ST_LOAD) || (r_state == ST_CRC);
  assign w_shift      = (r_state == ST_LOAD) && (r_vld != '0) && !abort;
  assign w_last_bit   = w_shift && (r_bit_cnt == LAST_IDX);
  assign w_accept     = s_valid && w_s_ready;
  assign w_crc_match  = (s_data == w_crc);

  // State register.
  always_ff @(posedge prog_clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort beats a same-cycle CRC byte accept.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort)           w_state_nxt = ST_ERR;
        else if (w_last_bit) w_state_nxt = ST_CRC;
      end
      ST_CRC: begin
        if (abort)         w_state_nxt = ST_ERR;
        else if (w_accept) w_state_nxt = w_crc_match ? ST_DONE : ST_ERR;
      end
      ST_DONE, ST_ERR: begin
        if (start) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake/status decode; refill when empty or on the last buffered bit,
  // but never once the final chain bit is leaving (that byte is the CRC).
  always_comb begin
    w_s_ready = 1'b0;
    w_busy    = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_busy    = 1'b1;
        w_s_ready = !abort && !w_last_bit &&
                    ((r_vld == '0) || (r_vld == VLD_W'(1)));
      end
      ST_CRC: begin
        w_busy    = 1'b1;
        w_s_ready = !abort;
      end
      default: begin
        w_s_ready = 1'b0;
        w_busy    = 1'b0;
      end
    endcase
  end

  // Shift buffer, bit counter, registered chain drive and sticky status flags.
  always_ff @(posedge prog_clk or posedge rst) begin
    if (rst) begin
      r_buf     <= '0;
      r_vld     <= '0;
      r_bit_cnt <= '0;
      r_prog_in <= 1'b0;
      r_prog_en <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_prog_en <= w_shift;
      r_prog_in <= w_shift ? r_buf[WORD_W-1] : 1'b0;
      if (w_start_load) begin
        r_buf     <= '0;
        r_vld     <= '0;
        r_bit_cnt <= '0;
        r_done    <= 1'b0;
        r_err     <= 1'b0;
      end else if (w_active) begin
        // Leftover bits of a partial final byte are dropped here.
        if (abort || w_last_bit) begin
          r_buf <= '0;
          r_vld <= '0;
        end else if (w_accept && (r_state == ST_LOAD)) begin
          r_buf <= s_data;
          r_vld <= VLD_W'(WORD_W);
        end else if (w_shift) begin
          r_buf <= {r_buf[WORD_W-2:0], 1'b0};
          r_vld <= r_vld - VLD_W'(1);
        end
        if (w_shift) begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
        if (abort) begin
          r_err <= 1'b1;
        end else if ((r_state == ST_CRC) && w_accept) begin
          r_done <= w_crc_match;
          r_err  <= !w_crc_match;
        end
      end
    end
  end

  crc8_serial u_crc (
    .i_clk (prog_clk),
    .i_rst (rst),
    .i_clr (w_start_load),
    .i_en  (w_shift),
    .i_bit (r_buf[WORD_W-1]),
    .o_crc (w_crc)
  );

  assign s_ready = w_s_ready;
  assign busy    = w_busy;
  assign prog_in = r_prog_in;
  assign prog_en = r_prog_en;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Scoreboard bench for cfg_bitstream_loader at chain lengths 12, 16 and 1.
`timescale 1ns/1ps
module tb_cfg_bitstream_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] start, abort, s_valid, s_ready, prog_in, prog_en, busy, done, err;
  logic [7:0] s_data [3];

  cfg_bitstream_loader #(.CHAIN_LEN(12), .WORD_W(8)) u_dut_l12 (
    .prog_clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
    .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .prog_in(prog_in[0]), .prog_en(prog_en[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0]));

  cfg_bitstream_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_dut_l16 (
    .prog_clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
    .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .prog_in(prog_in[1]), .prog_en(prog_en[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1]));

  cfg_bitstream_loader #(.CHAIN_LEN(1), .WORD_W(8)) u_dut_l1 (
    .prog_clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]),
    .s_data(s_data[2]), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
    .prog_in(prog_in[2]), .prog_en(prog_en[2]), .busy(busy[2]),
    .done(done[2]), .err(err[2]));

  int   n_vec = 0;
  int   n_err = 0;
  int   sel = 0;
  int   en_cnt = 0;
  int   en_rise = 0;
  int   en_base;
  int   rise_base;
  logic prev_en = 1'b0;
  logic exp_q [$];
  logic [7:0] m_crc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic [7:0] n;
    n = c << 1;
    if (c[7] ^ b) n = n ^ 8'h07;
    return n;
  endfunction

  // Every shifted chain bit is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (prog_en[sel]) begin
      en_cnt++;
      if (!prev_en) en_rise++;
      if (exp_q.size() == 0) chk("extra_bit", 32'd1, 32'd0);
      else chk("prog_in", 32'(prog_in[sel]), 32'(exp_q.pop_front()));
    end
    prev_en = prog_en[sel];
  end

  // Called at a negedge; offers d until accepted, pushing its first nbits.
  task automatic send_byte(input int k, input logic [7:0] d, input int nbits);
    int n;
    logic [7:0] t;
    s_valid[k] = 1'b1;
    s_data[k]  = d;
    n = 0;
    #1;
    while (!s_ready[k] && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (!s_ready[k]) begin
      chk("accept_timeout", 32'd1, 32'd0);
      s_valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    t = d;
    for (int i = 0; i < nbits; i++) begin
      exp_q.push_back(t[7]);
      m_crc = crc_step(m_crc, t[7]);
      t = t << 1;
    end
    @(negedge clk);
    s_valid[k] = 1'b0;
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  // One pulse from IDLE, two from DONE/ERR (first returns to IDLE).
  task automatic begin_load(input int k, input int pulses);
    sel = k;
    exp_q.delete();
    m_crc = 8'h00;
    en_base = en_cnt;
    rise_base = en_rise;
    for (int i = 0; i < pulses; i++) pulse_start(k);
    chk("load_entry", {29'd0, busy[k], s_ready[k], done[k] | err[k]}, 32'b110);
  endtask

  task automatic finish_load(input int k, input logic [7:0] crc_b, input logic ok, input int nbits);
    send_byte(k, crc_b, 0);
    chk("result", {30'd0, done[k], err[k]}, {30'd0, ok, !ok});
    chk("busy_end", 32'(busy[k]), 32'd0);
    chk("en_count", en_cnt - en_base, nbits);
    chk("q_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = '0; abort = '0; s_valid = '0;
    for (int i = 0; i < 3; i++) s_data[i] = 8'h00;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk("reset", {26'd0, prog_in[k], prog_en[k], s_ready[k], busy[k], done[k], err[k]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back bytes, partial last byte, reference CRC.
    begin_load(0, 1);
    send_byte(0, 8'hA5, 8);
    send_byte(0, 8'h3F, 4);
    finish_load(0, 8'h3C, 1'b1, 12);
    chk("l12_gapless", en_rise - rise_base, 32'd1);
    chk("l12_en_after", 32'(prog_en[0]), 32'd0);

    // Wrong CRC byte.
    begin_load(1, 1);
    send_byte(1, 8'h00, 8);
    send_byte(1, 8'h00, 8);
    finish_load(1, 8'h01, 1'b0, 16);

    // Single-bit chain.
    begin_load(2, 1);
    send_byte(2, 8'h80, 1);
    finish_load(2, m_crc, 1'b1, 1);
    chk("l1_crc_ref", 32'(m_crc), 32'h07);

    // Source stall between bytes.
    begin_load(0, 2);
    send_byte(0, 8'hA5, 8);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("gap_en", 32'(prog_en[0]), 32'd0);
    end
    send_byte(0, 8'h3F, 4);
    finish_load(0, m_crc, 1'b1, 12);

    // Abort after five bits with a byte offered on the same cycle.
    begin_load(0, 2);
    send_byte(0, 8'hA5, 8);
    repeat (5) @(negedge clk);
    abort[0] = 1'b1; s_valid[0] = 1'b1; s_data[0] = 8'h3F;
    #1;
    chk("abort_rdy", 32'(s_ready[0]), 32'd0);
    @(negedge clk);
    abort[0] = 1'b0; s_valid[0] = 1'b0;
    exp_q.delete();
    chk("abort_res", {28'd0, done[0], err[0], busy[0], prog_en[0]}, 32'b0100);
    chk("abort_bits", en_cnt - en_base, 32'd5);
    repeat (4) @(negedge clk);
    chk("abort_hold", en_cnt - en_base, 32'd5);

    // Clean rerun after abort.
    begin_load(0, 2);
    send_byte(0, 8'hA5, 8);
    send_byte(0, 8'h3F, 4);
    finish_load(0, 8'h3C, 1'b1, 12);

    // Abort in CRC state beats a correct CRC byte.
    begin_load(2, 2);
    send_byte(2, 8'h80, 1);
    @(negedge clk);
    abort[2] = 1'b1; s_valid[2] = 1'b1; s_data[2] = 8'h07;
    #1;
    chk("crc_abort_rdy", 32'(s_ready[2]), 32'd0);
    @(negedge clk);
    abort[2] = 1'b0; s_valid[2] = 1'b0;
    chk("crc_abort_res", {30'd0, done[2], err[2]}, 32'b01);

    // Asynchronous reset mid-load.
    begin_load(0, 2);
    send_byte(0, 8'hA5, 8);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {26'd0, prog_in[0], prog_en[0], s_ready[0], busy[0], done[0], err[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);

    // Start during LOAD is ignored.
    begin_load(0, 1);
    send_byte(0, 8'hA5, 8);
    @(negedge clk);
    pulse_start(0);
    chk("start_in_load", 32'(busy[0]), 32'd1);
    send_byte(0, 8'h3F, 4);
    finish_load(0, 8'h3C, 1'b1, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
